// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared encodings, FSM state type and lane helpers for the
//            memory-access pipeline stage.
// Options  : MEM_ACCESS_TIMEOUT_EN adds the TOUT state.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef MEM_ACCESS_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TOUT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1
    } state_t;
`endif

    // Little-endian byte enables; size 11 falls through to a full word.
    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr;
            SZ_HALF: be = 4'b0011 << {addr[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] addr, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {addr, 3'b000});
        h = addr[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Combinational lane logic: byte enables, store-data replication
//            and load extraction / sign or zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  mem_size,
    input  logic [1:0]  addr_lo,
    input  logic        mem_signed,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    // Replicate narrow store data so the enabled lanes always carry it.
    always_comb begin
        byte_en   = be_gen(mem_size, addr_lo);
        load_data = load_extend(load_word, mem_size, addr_lo, mem_signed);
        case (mem_size)
            SZ_BYTE: store_lanes = {4{store_data[7:0]}};
            SZ_HALF: store_lanes = {2{store_data[15:0]}};
            default: store_lanes = store_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MEM stage controller. Issues data-memory requests, stalls the
//            upstream pipeline during wait states, and bubbles MEM/WB while
//            stalled.
// Options  : MEM_ACCESS_TIMEOUT_EN - bounded WAIT with TOUT state and BusErr.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_stage_pkg::*;
`ifdef MEM_ACCESS_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] WriteData_in,
    input  logic        RegWrite2,
    input  logic [1:0]  MemtoReg2_in,
    input  logic [4:0]  EXMEMRTorRd_in,
    input  logic [31:0] PCAddResult_in,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWData,
    output logic [3:0]  DMemBE,
    input  logic        DMemReady,
    input  logic [31:0] DMemRData,
    output logic        Stall,
    output logic        RegWrite2_out,
    output logic [1:0]  MemtoReg2_out,
    output logic [31:0] ReadData,
    output logic [31:0] ALUResult_out,
    output logic [4:0]  EXMEMRTorRd,
    output logic [31:0] PCAddResult3,
    output logic        MisalignErr,
    output logic [31:0] StallCount
`ifdef MEM_ACCESS_TIMEOUT_EN
    ,
    output logic        BusErr
`endif
);

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [7:0] c_timeout_limit = 8'(TIMEOUT_CYCLES);
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       bus_err;
`endif

    state_t      state_q, state_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        access, misalign, mem_req, stall, done, reg_write;
    logic [31:0] load_fmt;

    assign access = MemRead | MemWrite;

    // Alignment check on the effective address; size 11 is checked as a word.
    always_comb begin
        misalign = 1'b0;
        if (access) begin
            case (MemSize)
                SZ_BYTE: misalign = 1'b0;
                SZ_HALF: misalign = ALUResult_in[0];
                default: misalign = |ALUResult_in[1:0];
            endcase
        end
    end

    mem_lane_align u_lane_align (
        .mem_size    (MemSize),
        .addr_lo     (ALUResult_in[1:0]),
        .mem_signed  (MemSigned),
        .store_data  (WriteData_in),
        .load_word   (DMemRData),
        .byte_en     (DMemBE),
        .store_lanes (DMemWData),
        .load_data   (load_fmt)
    );

    // Handshake FSM: next state, request, stall and MEM/WB bubble control.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        reg_write = RegWrite2 & ~access;
`ifdef MEM_ACCESS_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        bus_err    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (access && !misalign) begin
                    mem_req = 1'b1;
                    if (DMemReady) begin
                        done = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_WAIT;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        wait_cnt_d = 8'd1;
`endif
                    end
                end
            end
            ST_WAIT: begin
                mem_req = 1'b1;
                if (DMemReady) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    wait_cnt_d = 8'd0;
`endif
                end else begin
                    stall = 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    // The stall cycle spent in IDLE counts toward the limit.
                    if (wait_cnt_q + 8'd1 >= c_timeout_limit) begin
                        state_d    = ST_TOUT;
                        wait_cnt_d = 8'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
`endif
                end
            end
`ifdef MEM_ACCESS_TIMEOUT_EN
            ST_TOUT: begin
                bus_err   = 1'b1;
                reg_write = 1'b0;
                state_d   = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (done) begin
            reg_write = RegWrite2;
        end
        // Reset silences the bus and pipeline controls immediately.
        if (Reset) begin
            mem_req   = 1'b0;
            stall     = 1'b0;
            done      = 1'b0;
            reg_write = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            bus_err   = 1'b0;
`endif
        end
        stall_count_d = stall_count_q + {31'd0, stall};
    end

    // State, wait counter and stall statistics registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            stall_count_q <= 32'd0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wait_cnt_q    <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
`endif
        end
    end

    assign DMemReq       = mem_req;
    assign DMemWe        = mem_req & MemWrite;
    assign DMemAddr      = {ALUResult_in[31:2], 2'b00};
    assign Stall         = stall;
    assign RegWrite2_out = reg_write;
    assign MemtoReg2_out = MemtoReg2_in;
    assign ReadData      = (done && MemRead && !MemWrite) ? load_fmt : 32'd0;
    assign ALUResult_out = ALUResult_in;
    assign EXMEMRTorRd   = EXMEMRTorRd_in;
    assign PCAddResult3  = PCAddResult_in;
    assign MisalignErr   = misalign & ~Reset;
    assign StallCount    = stall_count_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    assign BusErr        = bus_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Directed and randomized self-checking bench for mem_access_stage.
// Options  : MEM_ACCESS_TIMEOUT_EN enables the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int LAT_MAX = 3;
`else
    localparam int LAT_MAX = 4;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MemRead, MemWrite, MemSigned, RegWrite2;
    logic [1:0]  MemSize, MemtoReg2_in;
    logic [31:0] ALUResult_in, WriteData_in, PCAddResult_in;
    logic [4:0]  EXMEMRTorRd_in;
    logic        DMemReq, DMemWe, DMemReady, Stall, RegWrite2_out, MisalignErr;
    logic [31:0] DMemAddr, DMemWData, DMemRData, ReadData, ALUResult_out, PCAddResult3, StallCount;
    logic [3:0]  DMemBE;
    logic [1:0]  MemtoReg2_out;
    logic [4:0]  EXMEMRTorRd;
`ifdef MEM_ACCESS_TIMEOUT_EN
    logic        BusErr;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_stalls = 32'd0;

    always #5 Clk = ~Clk;

`ifdef MEM_ACCESS_TIMEOUT_EN
    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemSigned(MemSigned), .ALUResult_in(ALUResult_in),
        .WriteData_in(WriteData_in), .RegWrite2(RegWrite2), .MemtoReg2_in(MemtoReg2_in),
        .EXMEMRTorRd_in(EXMEMRTorRd_in), .PCAddResult_in(PCAddResult_in),
        .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
        .DMemBE(DMemBE), .DMemReady(DMemReady), .DMemRData(DMemRData), .Stall(Stall),
        .RegWrite2_out(RegWrite2_out), .MemtoReg2_out(MemtoReg2_out), .ReadData(ReadData),
        .ALUResult_out(ALUResult_out), .EXMEMRTorRd(EXMEMRTorRd), .PCAddResult3(PCAddResult3),
        .MisalignErr(MisalignErr), .StallCount(StallCount), .BusErr(BusErr)
    );
`else
    mem_access_stage dut (
        .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemSigned(MemSigned), .ALUResult_in(ALUResult_in),
        .WriteData_in(WriteData_in), .RegWrite2(RegWrite2), .MemtoReg2_in(MemtoReg2_in),
        .EXMEMRTorRd_in(EXMEMRTorRd_in), .PCAddResult_in(PCAddResult_in),
        .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
        .DMemBE(DMemBE), .DMemReady(DMemReady), .DMemRData(DMemRData), .Stall(Stall),
        .RegWrite2_out(RegWrite2_out), .MemtoReg2_out(MemtoReg2_out), .ReadData(ReadData),
        .ALUResult_out(ALUResult_out), .EXMEMRTorRd(EXMEMRTorRd), .PCAddResult3(PCAddResult3),
        .MisalignErr(MisalignErr), .StallCount(StallCount)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input logic rw);
        MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sgn;
        ALUResult_in = addr; WriteData_in = wd; RegWrite2 = rw;
        MemtoReg2_in = 2'($urandom_range(0, 3));
        EXMEMRTorRd_in = 5'($urandom_range(0, 31));
        PCAddResult_in = $urandom;
    endtask

    // Reference model: access width in bytes decides alignment, lanes and extension.
    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdw,
                           input int lat, input logic rw);
        int          n, lane;
        logic        acc, mis;
        logic [3:0]  be;
        logic [31:0] wexp, rexp, mask;
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        acc  = rd | wr;
        mis  = acc && ((addr % n) != 0);
        lane = int'(addr % 4);
        be   = 4'(((1 << n) - 1) << lane);
        for (int i = 0; i < 4; i++) wexp[8*i +: 8] = wd[8*(i % n) +: 8];
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
        rexp = (rdw >> (8*lane)) & mask;
        if (sgn && n < 4 && rexp[8*n-1]) rexp = rexp | ~mask;

        drive(rd, wr, sz, sgn, addr, wd, rw);
        if (!acc || mis) begin
            DMemReady = 1'($urandom_range(0, 1));
            DMemRData = $urandom;
            @(negedge Clk);
            check1("req_idle", DMemReq, 1'b0);
            check1("stall_idle", Stall, 1'b0);
            check1("misalign", MisalignErr, mis);
            check1("rw_idle", RegWrite2_out, acc ? 1'b0 : rw);
            check("rdata_idle", ReadData, 32'd0);
            check("pass_alu", ALUResult_out, addr);
            check("pass_pc", PCAddResult3, PCAddResult_in);
            check("pass_misc", {25'd0, MemtoReg2_out, EXMEMRTorRd}, {25'd0, MemtoReg2_in, EXMEMRTorRd_in});
            @(posedge Clk); #1;
        end else begin
            for (int c = 0; c <= lat; c++) begin
                DMemReady = (c == lat);
                DMemRData = (c == lat) ? rdw : $urandom;
                @(negedge Clk);
                check1("req", DMemReq, 1'b1);
                check1("stall", Stall, c < lat);
                check1("rw", RegWrite2_out, (c == lat) ? rw : 1'b0);
                check1("misalign_ok", MisalignErr, 1'b0);
                if (c == lat) begin
                    check("addr", DMemAddr, addr & 32'hFFFF_FFFC);
                    check("be", {28'd0, DMemBE}, {28'd0, be});
                    check1("we", DMemWe, wr);
                    check("rdata", ReadData, wr ? 32'd0 : rexp);
                    if (wr) check("wdata", DMemWData, wexp);
                end
                @(posedge Clk); #1;
            end
            model_stalls = model_stalls + 32'(lat);
        end
        check("stall_count", StallCount, model_stalls);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        DMemReady = 1'b0;
        DMemRData = 32'd0;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 1'b1);
        @(posedge Clk); #1;
        @(negedge Clk);
        check1("rst_req", DMemReq, 1'b0);
        check1("rst_stall", Stall, 1'b0);
        check1("rst_rw", RegWrite2_out, 1'b0);
        check("rst_count", StallCount, 32'd0);
        ALUResult_in = 32'h101;
        #1 check1("rst_misalign", MisalignErr, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Zero-wait word load, signed byte load with 3 waits, half store, misaligned word.
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1);
        run_txn(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 3, 1'b1);
        check("plan_count3", StallCount, 32'd3);
        run_txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_1234, 32'h0, 0, 1'b0);
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 0, 1'b1);

        // Reset during the second WAIT cycle.
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 1'b1);
        DMemReady = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        #2 Reset = 1'b1;
        #1;
        check1("async_req", DMemReq, 1'b0);
        check1("async_stall", Stall, 1'b0);
        check("async_count", StallCount, 32'd0);
        @(negedge Clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        Reset = 1'b0;
        model_stalls = 32'd0;
        #1 check1("post_rst_idle", DMemReq, 1'b0);
        @(posedge Clk); #1;
        check("post_rst_count", StallCount, 32'd0);

        // Randomized mix of loads, stores, no-ops and misaligned accesses.
        for (int t = 0; t < 60; t++) begin
            int          kind, n, lat;
            logic        rd, wr;
            logic [1:0]  sz;
            logic [31:0] a;
            kind = int'($urandom_range(0, 9));
            rd   = (kind >= 2 && kind <= 5) || kind == 9;
            wr   = kind >= 6;
            sz   = 2'($urandom_range(0, 3));
            n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            a    = $urandom;
            if ($urandom_range(0, 9) < 8) a = a & ~32'(n - 1);
            lat  = int'($urandom_range(0, LAT_MAX));
            run_txn(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom, lat,
                    1'($urandom_range(0, 1)));
        end

`ifdef MEM_ACCESS_TIMEOUT_EN
        // Memory never answers: four stall cycles, one TOUT cycle, then IDLE.
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b1);
        DMemReady = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            check1("to_stall", Stall, 1'b1);
            check1("to_req", DMemReq, 1'b1);
            check1("to_buserr_low", BusErr, 1'b0);
            @(posedge Clk); #1;
        end
        @(negedge Clk);
        check1("tout_buserr", BusErr, 1'b1);
        check1("tout_stall", Stall, 1'b0);
        check1("tout_rw", RegWrite2_out, 1'b0);
        check1("tout_req", DMemReq, 1'b0);
        @(posedge Clk); #1;
        model_stalls = model_stalls + 32'd4;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge Clk);
        check1("after_tout_buserr", BusErr, 1'b0);
        check1("after_tout_req", DMemReq, 1'b0);
        check("after_tout_count", StallCount, model_stalls);
        @(posedge Clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
